sensor_frame_packer: RTL and testbench
======================================

// Module: sensor_frame_packer
// PURPOSE
//  Parametrised successor to the fixed 16-byte sensor snapshot buffer.
//  - Captures NUM_CH sensor channels of CH_W bits coherently on request.
//  - Serialises each capture as a framed byte stream: sync, sequence, data, pad, checksum.
//  - Output uses a valid/ready handshake with backpressure, feeding the UART/SPI link.
//  - Double-buffered so a new capture can be taken while the previous frame drains.
// PARAMETERS
//  NUM_CH     7      number of sensor channels (>=1)
//  CH_W       16     bits per channel; multiple of 8; BPC = CH_W/8
//  SYNC_BYTE  8'hA5  first byte of every frame
//  PAD_BYTES  2      zero bytes after the data (0..15)
//  CSUM_EN    1      1 = append checksum byte; 0 = no checksum byte
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             reset, asynchronous, active-low
//  ch_data    in   NUM_CH*CH_W   flattened channels; ch0 in the LSBs
//  snap_req   in   1             single-cycle capture request
//  m_data     out  8             stream byte
//  m_valid    out  1             m_data is valid
//  m_ready    in   1             sink accepts the byte when valid&ready at posedge
//  m_sof      out  1             high on the first byte (sync byte)
//  m_eof      out  1             high on the last byte of the frame
//  frame_cnt  out  8             number of captured frames, mod 256
//  overrun    out  1             1-cycle pulse: a request was dropped
// BEHAVIOUR
//  - Frame length: FRAME_LEN = 2 + NUM_CH*BPC + PAD_BYTES + CSUM_EN.
//  - Byte order:
//    - byte0 = SYNC_BYTE.
//    - byte1 = sequence number, equal to frame_cnt at the time of capture.
//    - Channels follow in order ch0..ch(NUM_CH-1), each little-endian (LS byte first).
//    - Then PAD_BYTES bytes of 8'h00.
//    - Then the checksum: 8-bit sum, mod 256, of all preceding bytes of the frame.
//  - Buffers:
//    - ACTIVE holds the frame being sent; PENDING is a one-deep queue.
//    - Each buffer holds the channel snapshot and its sequence number.
//  - Capture (snap_req=1 at a posedge):
//    - ch_data is sampled at that edge into ACTIVE if ACTIVE is free or being released
//      this edge with PENDING empty; otherwise into PENDING if PENDING is free or being
//      released this edge.
//    - Otherwise the request is dropped: overrun=1 for the next cycle only, frame_cnt unchanged.
//    - Every accepted request increments frame_cnt, wrapping 255->0.
//  - FSM states: IDLE and SEND.
//    - IDLE -> SEND on the edge after a capture into ACTIVE.
//    - SEND -> SEND when the eof byte is accepted and PENDING (or a same-edge request) is
//      loaded into ACTIVE. The next frame's sof appears the following cycle, with no gap.
//    - SEND -> IDLE when the eof byte is accepted and nothing is queued.
//  - Byte index: counts 0..FRAME_LEN-1, advances only on a handshake, and returns to 0
//    after eof.
//  - Handshake:
//    - m_valid=1 throughout SEND and never drops before the byte is accepted.
//    - m_data, m_sof and m_eof are stable while m_valid & !m_ready.
//    - Outputs come from registered state only; there is no combinational path from
//      ch_data or snap_req.
//  - Reset:
//    - Outputs: m_valid=0, m_data=0, m_sof=0, m_eof=0, overrun=0, frame_cnt=0.
//    - Internal: buffers cleared, index=0, state IDLE.
//    - Reset mid-frame aborts the frame; the partial frame is never resumed.
// TESTING (defaults, FRAME_LEN=19)
//  1. ch0=16'h1234, ch1..6=16'h0000, snap_req pulse, m_ready=1
//     -> A5,00,34,12,00x12,00,00,csum=8'hEB; sof on byte0, eof on byte18; frame_cnt=1.
//  2. Same stimulus with m_ready random 50%
//     -> identical 19 bytes; m_data/m_sof/m_eof stable during every stall.
//  3. Second snap_req at byte 5 with ch0=16'hBEEF, then ch_data changed
//     -> second frame back-to-back, seq 01, carries EF,BE.
//  4. Three snap_req during one frame
//     -> overrun pulses once; two frames emitted; frame_cnt=2.
//  5. 257 back-to-back captures -> seq byte runs ...FE,FF,00; frame_cnt wraps to 1.
//  6. rst_n asserted at byte 8 -> m_valid drops immediately; no output after release
//     until a new snap_req; the new frame carries seq 00.

Source files
------------

// File: rtl/sensor_frame_packer.sv
// sensor_frame_packer: double-buffered channel snapshot serialised as framed valid/ready bytes
module sensor_frame_packer #(
    parameter int          NUM_CH    = 7,
    parameter int          CH_W      = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          PAD_BYTES = 2,
    parameter int          CSUM_EN   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*CH_W-1:0] ch_data,
    input  logic                   snap_req,
    output logic [7:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eof,
    output logic [7:0]             frame_cnt,
    output logic                   overrun
);
    localparam int BPC       = CH_W / 8;
    localparam int DB        = NUM_CH * BPC;
    localparam int FRAME_LEN = 2 + DB + PAD_BYTES + CSUM_EN;
    localparam int IW        = $clog2(FRAME_LEN + 1);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0] DEND = IW'(2 + DB);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;

    logic [NUM_CH*CH_W-1:0] act_data, pend_data;
    logic [7:0]             act_seq, pend_seq, csum, data_byte;
    logic                   pend_valid, hs, rel, act_free, pend_free, to_act, to_pend;
    logic [IW-1:0]          idx;

    assign hs        = m_valid && m_ready;
    assign rel       = hs && m_eof;
    // ACTIVE can take a capture directly only when nothing is queued ahead of it
    assign act_free  = state == IDLE || (rel && !pend_valid);
    assign pend_free = !pend_valid || rel;
    assign to_act    = snap_req && act_free;
    assign to_pend   = snap_req && !act_free && pend_free;
    assign data_byte = 8'(act_data >> {idx - IW'(2), 3'b000});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (to_act || (rel && pend_valid)) ? SEND : rel ? IDLE : state;
    end

    always_comb begin
        m_valid = state == SEND;
        m_sof   = m_valid && idx == '0;
        m_eof   = m_valid && idx == LAST;
        m_data  = !m_valid                          ? 8'h00 :
                  idx == '0                         ? SYNC_BYTE :
                  idx == IW'(1)                     ? act_seq :
                  idx < DEND                        ? data_byte :
                  (CSUM_EN != 0 && idx == LAST)     ? csum : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data   <= '0;
            act_seq    <= '0;
            pend_data  <= '0;
            pend_seq   <= '0;
            pend_valid <= 1'b0;
            idx        <= '0;
            csum       <= '0;
            frame_cnt  <= '0;
            overrun    <= 1'b0;
        end else begin
            if (to_act) begin
                act_data <= ch_data;
                act_seq  <= frame_cnt;
            end else if (rel && pend_valid) begin
                act_data <= pend_data;
                act_seq  <= pend_seq;
            end
            if (to_pend) begin
                pend_data  <= ch_data;
                pend_seq   <= frame_cnt;
                pend_valid <= 1'b1;
            end else if (rel) begin
                pend_valid <= 1'b0;
            end
            if (hs) begin
                idx  <= rel ? '0 : idx + IW'(1);
                csum <= rel ? 8'h00 : csum + m_data;
            end
            frame_cnt <= frame_cnt + 8'(to_act || to_pend);
            overrun   <= snap_req && !to_act && !to_pend;
        end
    end
endmodule

// File: tb/tb_sensor_frame_packer.sv
// tb_sensor_frame_packer: directed frame, backpressure, queueing, wrap and reset scenarios
module tb_sensor_frame_packer;
    logic         clk, rst_n, snap_req, m_ready;
    logic [111:0] ch_data;
    logic [7:0]   m_data, frame_cnt;
    logic         m_valid, m_sof, m_eof, overrun;

    int checks = 0, errors = 0, stall_bad = 0, ovr_cnt = 0, cyc = 0;
    logic [9:0] bytes_q[$];
    int         ts_q[$];
    logic [7:0] exp1 [19] = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'hEB};

    sensor_frame_packer dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .snap_req(snap_req),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
        .m_eof(m_eof), .frame_cnt(frame_cnt), .overrun(overrun)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                bytes_q.push_back({m_sof, m_eof, m_data});
                ts_q.push_back(cyc);
            end
            if (overrun) ovr_cnt++;
        end
    end

    function automatic logic [7:0] fbyte(input logic [7:0] seq, input logic [111:0] d, input int i);
        logic [7:0] s = 8'hA5 + seq;
        for (int k = 0; k < 14; k++) s += d[8*k +: 8];
        return i == 0 ? 8'hA5 : i == 1 ? seq : i < 16 ? d[8*(i-2) +: 8] : i == 18 ? s : 8'h00;
    endfunction

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        rst_n = 0; snap_req = 0; m_ready = 0; ch_data = '0;
        tick; tick;
        rst_n = 1;
        tick;
        bytes_q.delete(); ts_q.delete(); ovr_cnt = 0; stall_bad = 0;
    endtask

    task pulse_req(input logic [111:0] d);
        ch_data = d; snap_req = 1;
        tick;
        snap_req = 0;
    endtask

    task automatic wait_bytes(input int n, input bit rnd);
        int budget = n * 4 + 50;
        logic [9:0] held;
        logic stalled;
        while (bytes_q.size() < n && budget > 0) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = m_valid && !m_ready;
            held = {m_sof, m_eof, m_data};
            tick;
            if (stalled && (!m_valid || {m_sof, m_eof, m_data} !== held)) stall_bad++;
            budget--;
        end
        m_ready = 1;
        checks++;
        if (bytes_q.size() < n) begin
            errors++;
            $display("FAIL wait_bytes: got %0d bytes, need %0d", bytes_q.size(), n);
        end
    endtask

    task test_reset;
        rst_n = 0; snap_req = 0; m_ready = 0; ch_data = '0;
        tick; tick;
        checks++;
        if ({m_valid, m_sof, m_eof, overrun, m_data, frame_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b sof=%b eof=%b ovr=%b data=%h cnt=%h, need all 0",
                     m_valid, m_sof, m_eof, overrun, m_data, frame_cnt);
        end
        rst_n = 1; m_ready = 1;
        repeat (5) tick;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: m_valid=%b need 0", m_valid);
        end
    endtask

    task test_single_frame;
        do_reset;
        pulse_req(112'h1234);
        wait_bytes(19, 0);
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (bytes_q[i] !== {1'(i == 0), 1'(i == 18), exp1[i]}) begin
                errors++;
                $display("FAIL single_byte%0d: got %h need %h", i, bytes_q[i], {1'(i == 0), 1'(i == 18), exp1[i]});
            end
        end
        checks++;
        if (frame_cnt !== 8'd1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_end: cnt=%h valid=%b need 01/0", frame_cnt, m_valid);
        end
    endtask

    task test_backpressure;
        do_reset;
        pulse_req(112'h1234);
        wait_bytes(19, 1);
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (bytes_q[i] !== {1'(i == 0), 1'(i == 18), exp1[i]}) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h need %h", i, bytes_q[i], {1'(i == 0), 1'(i == 18), exp1[i]});
            end
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL bp_stall_stable: %0d unstable stalls, need 0", stall_bad);
        end
    endtask

    task test_back_to_back;
        do_reset;
        pulse_req(112'h1234);
        wait_bytes(5, 0);
        pulse_req(112'hBEEF);
        ch_data = {7{16'h5A5A}};
        wait_bytes(38, 0);
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (bytes_q[i][7:0] !== fbyte(8'h00, 112'h1234, i) || bytes_q[19+i][7:0] !== fbyte(8'h01, 112'hBEEF, i)) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h/%h need %h/%h", i, bytes_q[i][7:0], bytes_q[19+i][7:0],
                         fbyte(8'h00, 112'h1234, i), fbyte(8'h01, 112'hBEEF, i));
            end
        end
        checks++;
        if (ts_q[19] - ts_q[18] !== 1 || bytes_q[19][9] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: gap=%0d sof=%b need 1/1", ts_q[19] - ts_q[18], bytes_q[19][9]);
        end
    endtask

    task test_overrun;
        do_reset;
        pulse_req(112'h1234);
        wait_bytes(3, 0);
        pulse_req(112'hCAFE);
        wait_bytes(8, 0);
        pulse_req(112'hDEAD);
        wait_bytes(38, 0);
        repeat (25) tick;
        checks++;
        if (ovr_cnt !== 1 || bytes_q.size() !== 38 || frame_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overrun: pulses=%0d bytes=%0d cnt=%0d need 1/38/2", ovr_cnt, bytes_q.size(), frame_cnt);
        end
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (bytes_q[19+i][7:0] !== fbyte(8'h01, 112'hCAFE, i)) begin
                errors++;
                $display("FAIL ovr_frame2_byte%0d: got %h need %h", i, bytes_q[19+i][7:0], fbyte(8'h01, 112'hCAFE, i));
            end
        end
    endtask

    task automatic test_wrap;
        int acc = 1, budget = 257 * 19 + 200;
        do_reset;
        m_ready = 1;
        pulse_req(112'h0);
        while (bytes_q.size() < 257 * 19 && budget > 0) begin
            snap_req = m_valid && m_sof && acc < 257;
            ch_data = 112'(acc);
            if (snap_req) acc++;
            tick;
            snap_req = 0;
            budget--;
        end
        checks++;
        if (bytes_q.size() < 257 * 19) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d bytes need %0d", bytes_q.size(), 257 * 19);
        end
        checks++;
        if ({bytes_q[19*254+1][7:0], bytes_q[19*255+1][7:0], bytes_q[19*256+1][7:0]} !== 24'hFEFF00) begin
            errors++;
            $display("FAIL wrap_seq: got %h %h %h need FE FF 00", bytes_q[19*254+1][7:0],
                     bytes_q[19*255+1][7:0], bytes_q[19*256+1][7:0]);
        end
        checks++;
        if ({bytes_q[19*256+2][7:0], bytes_q[19*256+3][7:0], bytes_q[19*256+18]} !== {8'h00, 8'h01, 10'h1A6}) begin
            errors++;
            $display("FAIL wrap_last_frame: ch0=%h%h tail=%h need 0100 tail 1a6", bytes_q[19*256+3][7:0],
                     bytes_q[19*256+2][7:0], bytes_q[19*256+18]);
        end
        checks++;
        if (frame_cnt !== 8'd1 || ts_q[257*19-1] - ts_q[0] !== 257 * 19 - 1) begin
            errors++;
            $display("FAIL wrap_cnt_gapless: cnt=%0d span=%0d need 1/%0d", frame_cnt, ts_q[257*19-1] - ts_q[0], 257 * 19 - 1);
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        do_reset;
        pulse_req(112'hBEEF);
        wait_bytes(8, 0);
        rst_n = 0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_drop: valid=%b data=%h need 0/00", m_valid, m_data);
        end
        tick;
        rst_n = 1;
        n = bytes_q.size();
        repeat (30) tick;
        checks++;
        if (bytes_q.size() !== n || m_valid !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_quiet: bytes=%0d valid=%b cnt=%0d need %0d/0/0", bytes_q.size(), m_valid, frame_cnt, n);
        end
        bytes_q.delete();
        pulse_req(112'h1234);
        wait_bytes(19, 0);
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (bytes_q[i] !== {1'(i == 0), 1'(i == 18), exp1[i]}) begin
                errors++;
                $display("FAIL rst_mid_new_byte%0d: got %h need %h", i, bytes_q[i], {1'(i == 0), 1'(i == 18), exp1[i]});
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_backpressure;
        test_back_to_back;
        test_overrun;
        test_wrap;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
